wb_result_fifo: RTL
===================

# wb_result_fifo

Wishbone classic responder that buffers 32-bit measurement results pushed by the frequency counter datapath. The control unit drains them over the shared bus without missing back-to-back measurements. It sits beside the UART and counter slaves on the OR-combined data/err/rty bus, so it must drive zero whenever it is not addressed. It provides a DATA pop register, a STATUS register, a CONTROL register, and a sticky overflow flag.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_3000, word-aligned base of a 16-byte register window
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 words (legal 2..10)

Ports:
- clk_i  in  1  system clock; the only clock
- rst_i  in  1  reset, synchronous and active-high
- addr_i  in  32  bus address
- dat_i  in  32  write data
- dat_o  out  32  read data; 0 unless acking a read
- we_i  in  1  write enable
- sel_i  in  4  byte selects
- cyc_i, stb_i  in  1  bus cycle / strobe
- lock_i, tagn_i  in  1  accepted, ignored
- ack_o, err_o, rty_o  out  1  termination; rty_o tied 0
- push_valid_i  in  1  result push strobe from the counter
- push_data_i  in  32  result word
- push_ready_o  out  1  high when not full
- fifo_level_o  out  DEPTH_LOG2+1  occupancy, for debug LEDs

## Operation
- Window hit: cyc_i & stb_i & (addr_i[31:4] == BASE_ADDR[31:4]). Outside the window the block gives no response, and dat_o/ack_o/err_o stay 0.
- Offsets (addr_i[3:2]):
  - 0 = DATA, read pops the head word.
  - 1 = STATUS, read-only: [15:0] level zero-extended, [16] empty, [17] full, [18] overflow.
  - 2 = CONTROL, write-only: bit0 flush, bit1 clear overflow, both self-clearing; applied only if sel_i[0].
  - 3 = reserved.
- Error cases, each answered with err_o instead of ack_o and with no side effect:
  - read of DATA when empty (evaluated at the request cycle)
  - write to DATA or STATUS
  - read of CONTROL
  - any access to offset 3
- Push: accepted when push_valid_i & (~full | pop in same cycle). If push_valid_i & full & no pop, the word is dropped and overflow (sticky) is set.
- Push and pop in the same cycle: level unchanged. When full, the push is accepted.
- Flush: level becomes 0, pointers reset, head data discarded. A simultaneous push is dropped and does not set overflow. Clear-overflow and an overflow event in the same cycle: the set wins.
- Level arithmetic is DEPTH_LOG2+1 bits. Pointers are DEPTH_LOG2 bits and wrap naturally mod depth.

## Timing
- Reset values: ack_o=0, err_o=0, rty_o=0, dat_o=0, push_ready_o=1, fifo_level_o=0, overflow=0, pointers=0.
- A request sampled at edge N produces ack_o/err_o and dat_o at N+1. Termination lasts exactly one cycle.
- No new request is decoded while ack_o or err_o is high. This guarantees one pop per transaction even if the master holds stb_i.
- The pop (read-pointer advance) commits at the same edge that raises ack_o. STATUS read returns the level as of request cycle N.
- Push to visible-at-head latency: a word pushed into an empty FIFO at edge N is readable by a request sampled at edge N+1.
- push_ready_o and fifo_level_o are registered and reflect state after the latest edge.
- A CONTROL write takes effect at the ack edge. A STATUS read one transaction later shows the result.
- rst_i asserted mid-transaction: ack_o/err_o drop at the next edge, contents are discarded, and no partial pop occurs.

## Structure
- Package wb_result_fifo_pkg holds:
  - register offsets: DATA=0, STATUS=1, CONTROL=2
  - STATUS bit positions: LEVEL_LSB=0, EMPTY_BIT=16, FULL_BIT=17, OVF_BIT=18
  - CONTROL bits: FLUSH_BIT=0, CLR_OVF_BIT=1
  - the window-size constant (16 bytes)
- One sub-module, result_fifo_mem: a synchronous 32 x depth storage array with registered read, plus pointer/level logic.
- The bus decode and termination FSM (IDLE -> RESP -> IDLE) lives in the top of this block.

## Test plan
- Reset, push 3 words (0x11, 0x22, 0x33), read DATA x3 -> acks one cycle after stb with dat_o 0x11, 0x22, 0x33 in order; STATUS then reads 0x0001_0000.
- Read DATA when empty -> err_o one cycle, ack_o=0, dat_o=0; level stays 0.
- With DEPTH_LOG2=4, push 17 words -> push_ready_o=0 after the 16th, 17th word dropped, STATUS=0x0006_0010; write CONTROL 0x2 -> STATUS=0x0002_0010.
- Full FIFO, push 0xAA in the same cycle a DATA read is accepted -> level stays 16, 0xAA is read last; pointers wrap correctly across 40 push/pop pairs.
- Write CONTROL 0x1 with push_valid_i high in the same cycle -> level 0, overflow 0, next DATA read returns err.
- Address BASE_ADDR+0x20, and stb_i held high across an ack -> no response/all outputs 0 for the former; exactly one pop for the latter; rst_i asserted during RESP clears all outputs the next cycle.

Source files
------------

// File: rtl/wb_result_fifo_pkg.sv
// Shared constants for the Wishbone result FIFO: register offsets, STATUS and
// CONTROL bit positions, and the size of the decoded register window.
package wb_result_fifo_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;

    localparam int LEVEL_LSB = 0;
    localparam int EMPTY_BIT = 16;
    localparam int FULL_BIT  = 17;
    localparam int OVF_BIT   = 18;

    localparam int FLUSH_BIT   = 0;
    localparam int CLR_OVF_BIT = 1;

    localparam int WINDOW_BYTES = 16;

endpackage

// File: rtl/wb_result_fifo_mem.sv
// Result storage: synchronous word array with a registered head read, plus the
// pointer, level, ready and sticky-overflow bookkeeping.
module result_fifo_mem #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pushValid,
    input  logic [31:0]           i_pushData,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic                  i_clrOvf,
    output logic [31:0]           o_rdData,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_overflow,
    output logic                  o_pushReady
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [31:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overflow;
    logic                  r_pushReady;
    logic [31:0]           r_rdData;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_pushAccept;
    logic                  w_ovfEvent;
    logic [DEPTH_LOG2:0]   w_levelNext;

    assign w_full  = (r_level == FULL_LEVEL);
    assign w_empty = (r_level == '0);
    assign w_pop   = i_pop & ~w_empty;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
    assign w_pushAccept = i_pushValid & (~w_full | w_pop) & ~i_flush;
    assign w_ovfEvent   = i_pushValid & w_full & ~w_pop & ~i_flush;

    always_comb begin
        w_levelNext = r_level;
        if (i_flush) begin
            w_levelNext = '0;
        end else if (w_pushAccept && !w_pop) begin
            w_levelNext = r_level + LEVEL_ONE;
        end else if (w_pop && !w_pushAccept) begin
            w_levelNext = r_level - LEVEL_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_pushAccept) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_pushReady <= 1'b1;
            r_rdData    <= '0;
        end else begin
            r_level     <= w_levelNext;
            r_pushReady <= (w_levelNext != FULL_LEVEL);
            if (i_flush) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
            end else begin
                if (w_pushAccept) begin
                    r_wrPtr <= r_wrPtr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rdPtr  <= r_rdPtr + PTR_ONE;
                    r_rdData <= r_mem[r_rdPtr];
                end
            end
            // An overflow in the same cycle as a clear request must stay visible.
            if (w_ovfEvent) begin
                r_overflow <= 1'b1;
            end else if (i_clrOvf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_rdData    = r_rdData;
    assign o_level     = r_level;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_overflow  = r_overflow;
    assign o_pushReady = r_pushReady;

endmodule

// File: rtl/wb_result_fifo.sv
// Wishbone classic responder draining counter results: decodes a 16-byte window
// into DATA/STATUS/CONTROL and answers each request with a one-cycle ack or err.
module wb_result_fifo
    import wb_result_fifo_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         dat_i,
    output logic [31:0]         dat_o,
    input  logic                we_i,
    input  logic [3:0]          sel_i,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                lock_i,
    input  logic                tagn_i,
    output logic                ack_o,
    output logic                err_o,
    output logic                rty_o,
    input  logic                push_valid_i,
    input  logic [31:0]         push_data_i,
    output logic                push_ready_o,
    output logic [DEPTH_LOG2:0] fifo_level_o
);

    localparam logic [0:0]  ST_IDLE     = 1'b0;
    localparam logic [0:0]  ST_RESP     = 1'b1;
    localparam logic [31:0] WINDOW_MASK = ~(32'(WINDOW_BYTES) - 32'd1);

    logic [0:0]          r_state;
    logic                r_ack;
    logic                r_err;
    logic                r_selData;
    logic [31:0]         r_statusData;

    logic                w_hit;
    logic                w_ack;
    logic                w_err;
    logic                w_pop;
    logic                w_flush;
    logic                w_clrOvf;
    logic                w_isDataRead;
    logic                w_isStatusRead;
    logic [31:0]         w_status;
    logic [31:0]         w_memRdData;
    logic [DEPTH_LOG2:0] w_level;
    logic                w_empty;
    logic                w_full;
    logic                w_overflow;
    logic                w_pushReady;
    logic                w_unused;

    assign w_unused = &{1'b0, lock_i, tagn_i, addr_i[1:0], dat_i[31:2], sel_i[3:1]};

    assign w_hit = cyc_i & stb_i & ((addr_i & WINDOW_MASK) == (BASE_ADDR & WINDOW_MASK));

    // Decoding only in IDLE guarantees one side effect per transaction even if stb_i is held.
    always_comb begin
        w_ack          = 1'b0;
        w_err          = 1'b0;
        w_pop          = 1'b0;
        w_flush        = 1'b0;
        w_clrOvf       = 1'b0;
        w_isDataRead   = 1'b0;
        w_isStatusRead = 1'b0;
        if (r_state == ST_IDLE && w_hit) begin
            case (addr_i[3:2])
                REG_DATA: begin
                    if (we_i || w_empty) begin
                        w_err = 1'b1;
                    end else begin
                        w_ack        = 1'b1;
                        w_pop        = 1'b1;
                        w_isDataRead = 1'b1;
                    end
                end
                REG_STATUS: begin
                    if (we_i) begin
                        w_err = 1'b1;
                    end else begin
                        w_ack          = 1'b1;
                        w_isStatusRead = 1'b1;
                    end
                end
                REG_CONTROL: begin
                    if (!we_i) begin
                        w_err = 1'b1;
                    end else begin
                        w_ack    = 1'b1;
                        w_flush  = sel_i[0] & dat_i[FLUSH_BIT];
                        w_clrOvf = sel_i[0] & dat_i[CLR_OVF_BIT];
                    end
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_status = '0;
        w_status[LEVEL_LSB +: DEPTH_LOG2 + 1] = w_level;
        w_status[EMPTY_BIT] = w_empty;
        w_status[FULL_BIT]  = w_full;
        w_status[OVF_BIT]   = w_overflow;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_selData    <= 1'b0;
            r_statusData <= '0;
        end else begin
            r_state      <= (w_ack || w_err) ? ST_RESP : ST_IDLE;
            r_ack        <= w_ack;
            r_err        <= w_err;
            r_selData    <= w_isDataRead;
            r_statusData <= w_isStatusRead ? w_status : 32'd0;
        end
    end

    result_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_pushValid (push_valid_i),
        .i_pushData  (push_data_i),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .i_clrOvf    (w_clrOvf),
        .o_rdData    (w_memRdData),
        .o_level     (w_level),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_overflow  (w_overflow),
        .o_pushReady (w_pushReady)
    );

    // The bus is OR-combined with other slaves, so data must be zero outside an ack.
    assign dat_o        = r_ack ? (r_selData ? w_memRdData : r_statusData) : 32'd0;
    assign ack_o        = r_ack;
    assign err_o        = r_err;
    assign rty_o        = 1'b0;
    assign push_ready_o = w_pushReady;
    assign fifo_level_o = w_level;

endmodule
